// File: rtl/timer_clock_select_if.sv
// Control/status bundle between the timer control register, the tick source and the Counter.
interface timer_clock_select_if #(
    parameter int unsigned PRESCALE_WIDTH = 10
);
    logic [2:0]                ClockSelect;
    logic                      ExtClock;
    logic                      PrescalerClear;
    logic                      CountTick;
    logic [1:0]                CounterEdge;
    logic [PRESCALE_WIDTH-1:0] Prescaler;

    // Control side: drives mode, pin and clear, observes the tick source.
    modport master (
        output ClockSelect,
        output ExtClock,
        output PrescalerClear,
        input  CountTick,
        input  CounterEdge,
        input  Prescaler
    );

    // Tick source side.
    modport slave (
        input  ClockSelect,
        input  ExtClock,
        input  PrescalerClear,
        output CountTick,
        output CounterEdge,
        output Prescaler
    );
endinterface

// File: rtl/timer_clock_select.sv
// Tick source for the 8-bit timer Counter: stop, SystemClock/N prescaler, or
// synchronised external pin (rising/falling). Emits a registered one-cycle CountTick
// per qualifying event and a registered CounterEdge code naming the live source.
module timer_clock_select #(
    parameter int unsigned PRESCALE_WIDTH = 10,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                 SystemClock,
    input  logic                 SystemReset,
    timer_clock_select_if.slave  bus
);

    // Edge detection stays masked until the synchroniser and history flop hold real pin data.
    localparam int unsigned ArmMax   = SYNC_STAGES + 1;
    localparam int unsigned ArmWidth = $clog2(ArmMax + 1);

    logic [PRESCALE_WIDTH-1:0] prescaler_q;
    logic [SYNC_STAGES-1:0]    sync_q;
    logic                      hist_q;
    logic [ArmWidth-1:0]       arm_q;
    logic                      tick_q;
    logic                      tick_d;
    logic [1:0]                edge_q;
    logic [1:0]                edge_d;

    logic ext_sync;
    logic armed;
    logic ext_rise;
    logic ext_fall;
    logic clear;

    assign ext_sync = sync_q[SYNC_STAGES-1];
    assign armed    = (arm_q == ArmWidth'(ArmMax));
    assign ext_rise = armed & ext_sync & ~hist_q;
    assign ext_fall = armed & ~ext_sync & hist_q;
    assign clear    = bus.PrescalerClear;

    // Free-running prescaler with synchronous clear.
    always_ff @(posedge SystemClock) begin
        if (SystemReset) begin
            prescaler_q <= '0;
        end else if (clear) begin
            prescaler_q <= '0;
        end else begin
            prescaler_q <= prescaler_q + 1'b1;
        end
    end

    // External pin synchroniser, edge history and post-reset arm counter; run in every mode.
    always_ff @(posedge SystemClock) begin
        if (SystemReset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            arm_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.ExtClock};
            hist_q <= ext_sync;
            if (arm_q != ArmWidth'(ArmMax)) begin
                arm_q <= arm_q + 1'b1;
            end
        end
    end

    // Decode the selected source into next tick and edge code.
    // Divider ticks fire on the cycle the low prescaler bits wrap, so the period is exactly N.
    always_comb begin
        tick_d = 1'b0;
        edge_d = 2'b00;
        unique case (bus.ClockSelect)
            3'b000: begin
                tick_d = 1'b0;
                edge_d = 2'b00;
            end
            3'b001: begin
                tick_d = 1'b1;
                edge_d = 2'b01;
            end
            3'b010: begin
                tick_d = (&prescaler_q[2:0]) & ~clear;
                edge_d = 2'b01;
            end
            3'b011: begin
                tick_d = (&prescaler_q[5:0]) & ~clear;
                edge_d = 2'b01;
            end
            3'b100: begin
                tick_d = (&prescaler_q[7:0]) & ~clear;
                edge_d = 2'b01;
            end
            3'b101: begin
                tick_d = (&prescaler_q[9:0]) & ~clear;
                edge_d = 2'b01;
            end
            3'b110: begin
                tick_d = ext_fall;
                edge_d = 2'b10;
            end
            3'b111: begin
                tick_d = ext_rise;
                edge_d = 2'b11;
            end
            default: begin
                tick_d = 1'b0;
                edge_d = 2'b00;
            end
        endcase
    end

    // Registered outputs to the Counter.
    always_ff @(posedge SystemClock) begin
        if (SystemReset) begin
            tick_q <= 1'b0;
            edge_q <= 2'b00;
        end else begin
            tick_q <= tick_d;
            edge_q <= edge_d;
        end
    end

    assign bus.CountTick   = tick_q;
    assign bus.CounterEdge = edge_q;
    assign bus.Prescaler   = prescaler_q;

endmodule
